// File: rtl/uart_tx_ctrl.sv
//------------------------------------------------------------------------------
// uart_tx_ctrl : UART transmit framer (start, LSB-first data, optional parity,
//                stop) paced by an external baud_tick strobe; outputs registered.
// Optional macro UART_TX_TWO_STOP_EN adds a second stop bit (STOP2).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  parity_bit,
  output logic [DATA_WIDTH-1:0] frame_data,
  output logic                  parity_en,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
    STOP   = 3'd4,
    STOP2  = 3'd5
`else
    STOP   = 3'd4
`endif
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]  shift, shift_nxt;
  logic [DATA_WIDTH-1:0]  frame_nxt;
  logic                   par_lat, par_lat_nxt;
  logic                   tx_out_nxt;
  logic                   busy_nxt;
  logic                   parity_en_nxt;
  logic                   tx_done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      shift      <= '0;
      frame_data <= '0;
      par_lat    <= 1'b0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      parity_en  <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      shift      <= shift_nxt;
      frame_data <= frame_nxt;
      par_lat    <= par_lat_nxt;
      tx_out     <= tx_out_nxt;
      busy       <= busy_nxt;
      parity_en  <= parity_en_nxt;
      tx_done    <= tx_done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shift_nxt   = shift;
    frame_nxt   = frame_data;
    par_lat_nxt = par_lat;

    case (state)
      IDLE: begin
        // Acceptance ignores baud_tick; the start bit runs until the next tick.
        if (data_valid) begin
          state_nxt   = START;
          shift_nxt   = p_data;
          frame_nxt   = p_data;
          par_lat_nxt = par_en;
          cnt_nxt     = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_nxt = shift >> 1;
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = par_lat ? PARITY : STOP;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
`ifdef UART_TX_TWO_STOP_EN
          state_nxt = STOP2;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef UART_TX_TWO_STOP_EN
      STOP2: begin
        if (baud_tick) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they describe.
  always_comb begin
    tx_out_nxt    = 1'b1;
    busy_nxt      = (state_nxt != IDLE);
    parity_en_nxt = (state == IDLE) && (state_nxt == START);
    tx_done_nxt   = (state != IDLE) && (state_nxt == IDLE);

    case (state_nxt)
      START:   tx_out_nxt = 1'b0;
      DATA:    tx_out_nxt = shift_nxt[0];
      PARITY:  tx_out_nxt = parity_bit;
      default: tx_out_nxt = 1'b1;
    endcase
  end

endmodule

`default_nettype wire
